ifetch_unit: RTL

Instruction fetch stage of the out-of-order RV32I core. Sits directly upstream of the combinational decoder. Holds the PC and issues one instruction-word request at a time to the instruction cache. Presents each fetched word to the decoder with a taken/not-taken prediction from a 2-bit BHT, re-presents JALR until the decoder resolves its target, and redirects on ROB clear.

---
 rtl/ifetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, single-outstanding icache request,
// decoder hand-off with 2-bit BHT prediction, JALR hold and flush.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        stall,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_valid,
  input  logic [31:0] icache_ins,
  output logic        to_dec_ok,
  output logic [31:0] to_dec_pc,
  output logic [31:0] to_dec_ins,
  output logic        to_dec_jp,
  input  logic        dec_jalr_ok,
  input  logic [31:0] dec_jalr_pc,
  input  logic        br_upd_valid,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic        buf_vld_q, buf_vld_d;
  logic [BHT_N-1:0][1:0] bht_q, bht_d;

  logic [6:0]  opcode;
  logic        is_jal;
  logic        is_br;
  logic        is_jalr;
  logic        pred;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] seq_pc;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] up_idx;
  logic        unused_bits;

  assign opcode  = buf_ins_q[6:0];
  assign is_jal  = (opcode == 7'b1101111);
  assign is_br   = (opcode == 7'b1100011);
  assign is_jalr = (opcode == 7'b1100111);

  assign j_imm = {{12{buf_ins_q[31]}}, buf_ins_q[19:12],
                  buf_ins_q[20], buf_ins_q[30:21], 1'b0};
  assign b_imm = {{20{buf_ins_q[31]}}, buf_ins_q[7],
                  buf_ins_q[30:25], buf_ins_q[11:8], 1'b0};

  assign rd_idx = buf_pc_q[BHT_IDX_W+1:2];
  assign up_idx = br_upd_pc[BHT_IDX_W+1:2];
  assign pred   = bht_q[rd_idx][1];

  assign unused_bits = ^{br_upd_pc[31:BHT_IDX_W+2], br_upd_pc[1:0]};

  assign icache_req  = ~rst & rdy & ~clear & ~stall
                     & (state_q == S_REQ);
  assign icache_addr = pc_q;

  assign to_dec_ok  = ~rst & rdy & ~clear & ~stall & buf_vld_q
                    & (state_q == S_ISSUE);
  assign to_dec_pc  = buf_pc_q;
  assign to_dec_ins = buf_ins_q;
  assign to_dec_jp  = to_dec_ok & (is_jal | (is_br & pred));

  always_comb begin
    seq_pc = buf_pc_q + 32'd4;
    unique case (1'b1)
      is_jal:  seq_pc = buf_pc_q + j_imm;
      is_br:   seq_pc = pred ? buf_pc_q + b_imm : buf_pc_q + 32'd4;
      default: seq_pc = buf_pc_q + 32'd4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_pc_d  = buf_pc_q;
    buf_ins_d = buf_ins_q;
    buf_vld_d = buf_vld_q;
    if (rdy) begin
      if (clear) begin
        pc_d      = clear_pc;
        buf_vld_d = 1'b0;
        // one response is still in flight and must be swallowed
        if ((state_q == S_WAIT || state_q == S_DRAIN) && !icache_valid)
          state_d = S_DRAIN;
        else
          state_d = S_REQ;
      end else begin
        unique case (state_q)
          S_REQ: begin
            if (icache_req) state_d = S_WAIT;
          end
          S_WAIT: begin
            if (icache_valid) begin
              buf_pc_d  = pc_q;
              buf_ins_d = icache_ins;
              buf_vld_d = 1'b1;
              state_d   = S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (to_dec_ok) begin
              if (is_jalr) begin
                if (dec_jalr_ok) begin
                  pc_d      = dec_jalr_pc;
                  buf_vld_d = 1'b0;
                  state_d   = S_REQ;
                end
              end else begin
                pc_d      = seq_pc;
                buf_vld_d = 1'b0;
                state_d   = S_REQ;
              end
            end
          end
          S_DRAIN: begin
            if (icache_valid) state_d = S_REQ;
          end
          default: state_d = S_REQ;
        endcase
      end
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (rdy && br_upd_valid) begin
      if (br_upd_taken) begin
        if (bht_q[up_idx] != 2'b11)
          bht_d[up_idx] = bht_q[up_idx] + 2'b01;
      end else begin
        if (bht_q[up_idx] != 2'b00)
          bht_d[up_idx] = bht_q[up_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      buf_pc_q  <= 32'h0;
      buf_ins_q <= 32'h0;
      buf_vld_q <= 1'b0;
      bht_q     <= {BHT_N{2'b01}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_pc_q  <= buf_pc_d;
      buf_ins_q <= buf_ins_d;
      buf_vld_q <= buf_vld_d;
      bht_q     <= bht_d;
    end
  end

endmodule
